// File: rtl/tick_monitor_pkg.sv
// tick_monitor_pkg: shared state encoding and defaults for tick_monitor.
// Defining TICK_FALL_EN adds tick_fall and high_time outputs to tick_monitor and a fall output to sync_edge.
package tick_monitor_pkg;
  localparam int CNT_W_DEF = 26;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: N-stage synchronizer with registered rise (and, with TICK_FALL_EN, fall) pulses.
module sync_edge #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
`ifdef TICK_FALL_EN
  ,
  output logic fall
`endif
);
  logic [N-1:0] sync_q, sync_d;
  logic prev_q, prev_d, rise_q, rise_d;
  logic sync_out;
  assign sync_out = sync_q[N-1];
  assign rise = rise_q;
  always_comb begin
    sync_d = {sync_q[N-2:0], d};
    prev_d = sync_out;
    rise_d = sync_out & ~prev_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end
`ifdef TICK_FALL_EN
  logic fall_q, fall_d;
  assign fall = fall_q;
  always_comb fall_d = ~sync_out & prev_q;
  always_ff @(posedge clk) fall_q <= rst ? 1'b0 : fall_d;
`endif
endmodule

// File: rtl/tick_monitor.sv
// tick_monitor: turns an async slow clock into clkin-domain ticks, measures its period and reports lock/loss.
// Defining TICK_FALL_EN adds tick_fall and high_time outputs.
module tick_monitor
  import tick_monitor_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter int               SYNC_STAGES = 2,
  parameter int               LOCK_COUNT  = 4,
  parameter int               TOL         = 0,
  parameter logic [CNT_W-1:0] TIMEOUT     = {CNT_W{1'b1}}
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             slowin,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             lost
`ifdef TICK_FALL_EN
  ,
  output logic             tick_fall,
  output logic [CNT_W-1:0] high_time
`endif
);
  localparam int MW = $clog2(LOCK_COUNT) + 1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [MW-1:0] match_q, match_d;
  logic locked_q, locked_d, lost_q, lost_d;
  logic [CNT_W:0] new_p, diff;
  logic hit, sat;
`ifdef TICK_FALL_EN
  logic fall;
  sync_edge #(.N(SYNC_STAGES)) u_sync (.clk(clkin), .rst(reset), .d(slowin), .rise(tick), .fall(fall));
`else
  sync_edge #(.N(SYNC_STAGES)) u_sync (.clk(clkin), .rst(reset), .d(slowin), .rise(tick));
`endif
  assign period = period_q;
  assign locked = locked_q;
  assign lost = lost_q;
  always_comb begin
    sat = &cnt_q;
    new_p = {1'b0, cnt_q} + (CNT_W+1)'(1);
    diff = new_p >= {1'b0, period_q} ? new_p - {1'b0, period_q} : {1'b0, period_q} - new_p;
    hit = diff <= (CNT_W+1)'(TOL);
    state_d = state_q;
    cnt_d = sat ? cnt_q : cnt_q + CNT_W'(1);
    period_d = period_q;
    match_d = match_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = tick ? MEASURE : IDLE;
      end
      MEASURE, LOCKED: begin
        if (tick) begin
          cnt_d = '0;
          period_d = sat ? cnt_q : new_p[CNT_W-1:0];
          match_d = !hit ? '0 : state_q == LOCKED ? match_q : match_q + MW'(1);
          state_d = !hit ? MEASURE : (state_q == LOCKED || match_q == MW'(LOCK_COUNT-2)) ? LOCKED : MEASURE;
        end else if (cnt_q == TIMEOUT) begin
          state_d = LOST;
          match_d = '0;
        end
      end
      default: begin
        if (tick) begin
          cnt_d = '0;
          state_d = MEASURE;
        end
      end
    endcase
    locked_d = state_d == LOCKED;
    lost_d = state_d == LOST;
  end
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      period_q <= '0;
      match_q <= '0;
      locked_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
      match_q <= match_d;
      locked_q <= locked_d;
      lost_q <= lost_d;
    end
  end
`ifdef TICK_FALL_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d, high_q, high_d, hnext;
  assign tick_fall = fall;
  assign high_time = high_q;
  always_comb begin
    hnext = &hcnt_q ? hcnt_q : hcnt_q + CNT_W'(1);
    hcnt_d = tick ? '0 : hnext;
    high_d = fall ? hnext : high_q;
  end
  always_ff @(posedge clkin) begin
    if (reset) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end
`endif
endmodule
